// File: rtl/fetch_pc_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | fetch_pc_unit: IF-stage PC generator with MIPS delay slot, IF/ID reg   |
// | rev 1.0                                                                |
// +------------------------------------------------------------------------+
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic        jump,
  input  logic        jr,
  input  logic [2:0]  branch,
  input  logic [25:0] instr_index,
  input  logic [15:0] br_offset,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        exc_valid,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_inst,
  output logic        if_id_valid,
  output logic        if_id_adel,
  output logic [31:0] link_addr,
  output logic        br_taken
);

  logic [31:0] pc;
  logic [31:0] id_pc_plus4;
  logic [31:0] br_target;
  logic [31:0] jump_target;
  logic [31:0] next_pc;
  logic        cond;
  logic        fetch_misaligned;

  assign id_pc_plus4      = id_pc + 32'd4;
  assign link_addr        = id_pc + 32'd8;
  assign br_target        = id_pc_plus4 + {{14{br_offset[15]}}, br_offset, 2'b00};
  assign jump_target      = {id_pc_plus4[31:28], instr_index, 2'b00};
  assign fetch_misaligned = (pc[1:0] != 2'b00);
  assign imem_addr        = pc;

  always_comb begin
    cond = 1'b0;
    case (branch)
      3'b010:  cond = (rs_data == rt_data);
      3'b011:  cond = (rs_data != rt_data);
      3'b100:  cond = !rs_data[31] && (rs_data != 32'd0);
      3'b101:  cond = rs_data[31];
      3'b110:  cond = !rs_data[31];
      3'b111:  cond = rs_data[31] || (rs_data == 32'd0);
      default: cond = 1'b0;
    endcase
  end

  assign br_taken = id_valid & (jump | cond) & ~stall;

  // jump takes precedence over any branch encoding present in the same slot
  always_comb begin
    next_pc = pc + 32'd4;
    if (id_valid && jump) begin
      next_pc = jr ? rs_data : jump_target;
    end else if (id_valid && cond) begin
      next_pc = br_target;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      if_id_pc    <= 32'd0;
      if_id_inst  <= 32'd0;
      if_id_valid <= 1'b0;
      if_id_adel  <= 1'b0;
    end else if (exc_valid || eret) begin
      pc          <= exc_valid ? EXC_VECTOR : epc;
      if_id_inst  <= 32'd0;
      if_id_valid <= 1'b0;
      if_id_adel  <= 1'b0;
    end else if (!stall) begin
      // the word being fetched now is the delay slot and is always kept
      pc          <= next_pc;
      if_id_pc    <= pc;
      if_id_inst  <= fetch_misaligned ? 32'd0 : imem_rdata;
      if_id_valid <= 1'b1;
      if_id_adel  <= fetch_misaligned;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
// Bench for fetch_pc_unit: directed literal checks plus randomized run
// against a behavioural next-PC model.
module tb_fetch_pc_unit;

  localparam logic [31:0] RESET_PC   = 32'hBFC0_0000;
  localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        rst_n, stall, id_valid, jump, jr, exc_valid, eret;
  logic [31:0] id_pc, rs_data, rt_data, epc, imem_rdata;
  logic [2:0]  branch;
  logic [25:0] instr_index;
  logic [15:0] br_offset;
  logic [31:0] imem_addr, if_id_pc, if_id_inst, link_addr;
  logic        if_id_valid, if_id_adel, br_taken;

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_on   = 1'b0;

  logic [31:0] m_pc, m_ifpc, m_inst;
  logic        m_v, m_adel;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, a[31:16]};
  endfunction

  assign imem_rdata = rom(imem_addr);

  fetch_pc_unit #(.RESET_PC(RESET_PC), .EXC_VECTOR(EXC_VECTOR)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .id_valid(id_valid), .id_pc(id_pc),
    .jump(jump), .jr(jr), .branch(branch), .instr_index(instr_index),
    .br_offset(br_offset), .rs_data(rs_data), .rt_data(rt_data),
    .exc_valid(exc_valid), .eret(eret), .epc(epc), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .if_id_pc(if_id_pc), .if_id_inst(if_id_inst),
    .if_id_valid(if_id_valid), .if_id_adel(if_id_adel), .link_addr(link_addr),
    .br_taken(br_taken)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  function automatic bit cond_true(input logic [2:0] b, input logic [31:0] a, input logic [31:0] c);
    case (b)
      3'd2:    return a == c;
      3'd3:    return a != c;
      3'd4:    return $signed(a) > 0;
      3'd5:    return $signed(a) < 0;
      3'd6:    return $signed(a) >= 0;
      3'd7:    return $signed(a) <= 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] cur);
    logic signed [31:0] off;
    off = 32'(signed'(br_offset));
    if (id_valid && jump)
      return jr ? rs_data : (((id_pc + 32'd4) & 32'hF000_0000) | (32'(instr_index) << 2));
    if (id_valid && cond_true(branch, rs_data, rt_data))
      return id_pc + 32'd4 + 32'(off * 4);
    return cur + 32'd4;
  endfunction

  // reference model: one step per rising edge, using the inputs held across it
  always @(posedge clk) begin
    if (!rst_n) begin
      m_pc = RESET_PC; m_ifpc = 32'd0; m_inst = 32'd0; m_v = 1'b0; m_adel = 1'b0;
    end else if (exc_valid || eret) begin
      m_pc = exc_valid ? EXC_VECTOR : epc;
      m_inst = 32'd0; m_v = 1'b0; m_adel = 1'b0;
    end else if (!stall) begin
      m_ifpc = m_pc;
      m_adel = (m_pc % 4) != 0;
      m_inst = m_adel ? 32'd0 : rom(m_pc);
      m_v    = 1'b1;
      m_pc   = model_next(m_pc);
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      check("imem_addr", imem_addr, m_pc);
      check("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_v});
      check("if_id_adel", {31'd0, if_id_adel}, {31'd0, m_adel});
      check("if_id_inst", if_id_inst, m_inst);
      if (m_v) check("if_id_pc", if_id_pc, m_ifpc);
      check("link_addr", link_addr, id_pc + 32'd8);
      check("br_taken", {31'd0, br_taken},
            {31'd0, id_valid && (jump || cond_true(branch, rs_data, rt_data)) && !stall});
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    stall = 0; id_valid = 0; jump = 0; jr = 0; branch = 3'd0; exc_valid = 0; eret = 0;
    instr_index = 26'd0; br_offset = 16'd0; rs_data = 32'd0; rt_data = 32'd0;
    id_pc = 32'd0; epc = 32'd0;
  endtask

  initial begin
    logic [31:0] r;
    rst_n = 0;
    idle_inputs();
    tick(); tick();
    check("rst imem_addr", imem_addr, 32'hBFC0_0000);
    check("rst valid", {31'd0, if_id_valid}, 32'd0);
    check("rst if_id_pc", if_id_pc, 32'd0);
    check("rst inst", if_id_inst, 32'd0);
    mon_on = 1'b1;
    rst_n = 1;
    tick();
    check("rel pc+4", imem_addr, 32'hBFC0_0004);
    check("rel if_id_pc", if_id_pc, 32'hBFC0_0000);
    check("rel inst", if_id_inst, rom(32'hBFC0_0000));
    tick();
    check("rel pc+8", imem_addr, 32'hBFC0_0008);
    tick(); tick(); tick();
    check("pre beq pc", imem_addr, 32'hBFC0_0014);
    // BEQ at BFC00010, delay slot BFC00014
    id_valid = 1; branch = 3'b010; rs_data = 5; rt_data = 5; br_offset = 16'd3;
    id_pc = 32'hBFC0_0010;
    #1;
    check("beq taken", {31'd0, br_taken}, 32'd1);
    check("beq link", link_addr, 32'hBFC0_0018);
    tick();
    check("beq slot pc", if_id_pc, 32'hBFC0_0014);
    check("beq slot valid", {31'd0, if_id_valid}, 32'd1);
    check("beq target", imem_addr, 32'hBFC0_0020);
    // BLTZ not taken then taken
    branch = 3'b101; rs_data = 32'h0000_0001; id_pc = 32'hBFC0_0020;
    #1;
    check("bltz nt", {31'd0, br_taken}, 32'd0);
    tick();
    check("bltz nt pc", imem_addr, 32'hBFC0_0024);
    rs_data = 32'hFFFF_FFFF;
    #1;
    check("bltz t", {31'd0, br_taken}, 32'd1);
    tick();
    check("bltz t pc", imem_addr, 32'hBFC0_0030);
    // misaligned JR
    branch = 3'd0; jump = 1; jr = 1; rs_data = 32'hBFC0_0102;
    tick();
    check("jr pc", imem_addr, 32'hBFC0_0102);
    idle_inputs();
    tick();
    check("jr adel", {31'd0, if_id_adel}, 32'd1);
    check("jr inst", if_id_inst, 32'd0);
    check("jr valid", {31'd0, if_id_valid}, 32'd1);
    // exception overrides stall
    stall = 1; exc_valid = 1;
    tick();
    check("exc pc", imem_addr, 32'hBFC0_0380);
    check("exc valid", {31'd0, if_id_valid}, 32'd0);
    check("exc inst", if_id_inst, 32'd0);
    idle_inputs();
    tick();
    check("post exc pc", imem_addr, 32'hBFC0_0384);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall pc", imem_addr, 32'hBFC0_0384);
      check("stall if_id_pc", if_id_pc, 32'hBFC0_0380);
      check("stall inst", if_id_inst, rom(32'hBFC0_0380));
    end
    // eret beats a simultaneous jump
    stall = 0; eret = 1; epc = 32'hBFC0_0040; jump = 1; id_valid = 1;
    instr_index = 26'h123; id_pc = 32'hBFC0_0380;
    tick();
    check("eret pc", imem_addr, 32'hBFC0_0040);
    check("eret valid", {31'd0, if_id_valid}, 32'd0);
    // reset during stall
    idle_inputs();
    stall = 1; rst_n = 0;
    tick();
    check("rst stall pc", imem_addr, 32'hBFC0_0000);
    check("rst stall valid", {31'd0, if_id_valid}, 32'd0);
    rst_n = 1; stall = 0;

    for (int i = 0; i < 3000; i++) begin
      tick();
      rst_n       = ($urandom_range(0, 199) != 0);
      exc_valid   = ($urandom_range(0, 59) == 0);
      eret        = ($urandom_range(0, 59) == 0);
      stall       = ($urandom_range(0, 3) == 0);
      id_valid    = $urandom_range(0, 1) == 1;
      jump        = ($urandom_range(0, 4) == 0);
      jr          = $urandom_range(0, 1) == 1;
      branch      = 3'($urandom_range(0, 7));
      instr_index = 26'($urandom);
      br_offset   = 16'($urandom);
      id_pc       = $urandom & 32'hFFFF_FFFC;
      r           = $urandom;
      rs_data     = r[0] ? $urandom : 32'($signed(4'($urandom)));
      rt_data     = r[1] ? rs_data : $urandom;
      if (r[7:3] != 0) rs_data[1:0] = rs_data[1:0] & {2{jump & jr & r[2]}};
      epc         = $urandom & 32'hFFFF_FFFC;
    end
    tick();
    mon_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
